// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned WORD_SIZE    = 16;
    localparam int unsigned LATENCY      = 2;
    localparam int unsigned STARVE_LIMIT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and shared-memory signals around the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned W = mem_arb_pkg::WORD_SIZE
);
    logic         i_req;
    logic [W-1:0] i_addr;
    logic [W-1:0] i_data;
    logic         i_ready;
    logic         i_stall;

    logic         d_read;
    logic         d_write;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_ready;
    logic         d_stall;

    logic         m_read;
    logic         m_write;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata,
        output i_data, i_ready, i_stall, d_rdata, d_ready, d_stall,
               m_read, m_write, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata,
        input  i_data, i_ready, i_stall, d_rdata, d_ready, d_stall,
               m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/arb_latency_counter.sv
// Access-latency down-counter: loads on grant, counts down while busy, flags zero.
module arb_latency_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    localparam logic [W-1:0] ONE = W'(1'b1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: data port preferred, fetch port forced through after
// STARVE_LIMIT consecutive data grants made while it was waiting.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE    = mem_arb_pkg::WORD_SIZE,
    parameter int unsigned LATENCY      = mem_arb_pkg::LATENCY,
    parameter int unsigned STARVE_LIMIT = mem_arb_pkg::STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus,
    output logic [15:0]   conflict_cnt
);
    import mem_arb_pkg::*;

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0]    STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0]    STREAK_ONE = SW'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);

    arb_state_e           state_q;
    logic [SW-1:0]        d_streak_q, d_streak_d;
    logic [15:0]          conflict_q, conflict_d;
    logic                 m_read_q, m_write_q;
    logic [WORD_SIZE-1:0] m_addr_q, m_wdata_q, i_data_q, d_rdata_q;

    logic d_req_s, starve_s, grant_d_s, grant_i_s, busy_s, cnt_zero_s;
    logic i_ready_s, d_ready_s, i_stall_s, d_stall_s;

    assign d_req_s   = bus.d_read | bus.d_write;
    assign starve_s  = (d_streak_q == STREAK_MAX) && bus.i_req;
    assign grant_d_s = (state_q == IDLE) && d_req_s && !starve_s;
    assign grant_i_s = (state_q == IDLE) && bus.i_req && !grant_d_s;
    assign busy_s    = (state_q != IDLE);
    assign i_ready_s = (state_q == I_ACC) && cnt_zero_s;
    assign d_ready_s = (state_q == D_ACC) && cnt_zero_s;
    assign i_stall_s = bus.i_req & ~i_ready_s;
    assign d_stall_s = d_req_s & ~d_ready_s;

    arb_latency_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (grant_d_s | grant_i_s),
        .load_val_i (CNT_LOAD),
        .dec_i      (busy_s),
        .zero_o     (cnt_zero_s)
    );

    // Streak of data grants taken while a fetch was waiting, plus conflict count.
    always_comb begin
        d_streak_d = d_streak_q;
        conflict_d = conflict_q;
        if (grant_i_s) begin
            d_streak_d = '0;
        end else if (grant_d_s && bus.i_req) begin
            d_streak_d = (d_streak_q == STREAK_MAX) ? d_streak_q : (d_streak_q + STREAK_ONE);
        end else if ((state_q == IDLE) && !bus.i_req) begin
            d_streak_d = '0;
        end else begin
            d_streak_d = d_streak_q;
        end
        if (i_stall_s && d_stall_s) begin
            conflict_d = conflict_q + 16'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    // Arbitration FSM with registered memory command and captured read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            d_streak_q <= '0;
            conflict_q <= 16'd0;
            m_read_q   <= 1'b0;
            m_write_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_data_q   <= '0;
            d_rdata_q  <= '0;
        end else begin
            d_streak_q <= d_streak_d;
            conflict_q <= conflict_d;
            case (state_q)
                IDLE: begin
                    if (grant_d_s) begin
                        state_q   <= D_ACC;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_write_q <= bus.d_write;
                        m_read_q  <= ~bus.d_write;
                    end else if (grant_i_s) begin
                        state_q   <= I_ACC;
                        m_addr_q  <= bus.i_addr;
                        m_read_q  <= 1'b1;
                        m_write_q <= 1'b0;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                I_ACC: begin
                    if (cnt_zero_s) begin
                        state_q  <= IDLE;
                        m_read_q <= 1'b0;
                        i_data_q <= bus.m_rdata;
                    end else begin
                        state_q  <= I_ACC;
                    end
                end
                D_ACC: begin
                    if (cnt_zero_s) begin
                        state_q   <= IDLE;
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        d_rdata_q <= bus.m_rdata;
                    end else begin
                        state_q   <= D_ACC;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_read_q  <= 1'b0;
                    m_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_read    = m_read_q;
    assign bus.m_write   = m_write_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.i_ready   = i_ready_s;
    assign bus.d_ready   = d_ready_s;
    assign bus.i_stall   = i_stall_s;
    assign bus.d_stall   = d_stall_s;
    assign bus.i_data    = i_ready_s ? bus.m_rdata : i_data_q;
    assign bus.d_rdata   = d_ready_s ? bus.m_rdata : d_rdata_q;
    assign conflict_cnt  = conflict_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter; read data is scoreboarded per port.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [15:0] conflict_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] i_exp_q[$];
    logic [15:0] d_exp_q[$];
    logic [15:0] i_exp_v, d_exp_v;

    mem_arbiter_if #(.W(16)) bus ();

    mem_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    function automatic logic [15:0] rdata_f(input logic [15:0] a);
        if (a == 16'h0010) return 16'hABCD;
        else return a ^ 16'h5A5A;
    endfunction

    assign bus.m_rdata = rdata_f(bus.m_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every ready pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.i_ready === 1'b1) begin
            n_cmp++;
            if (i_exp_q.size() == 0) begin
                n_err++;
                $display("FAIL i_ready_unexpected: got i_ready=1 expected 0 (no fetch pending)");
            end else begin
                i_exp_v = i_exp_q.pop_front();
                if (bus.i_data !== i_exp_v) begin
                    n_err++;
                    $display("FAIL sb_i_data: got %h expected %h", bus.i_data, i_exp_v);
                end
            end
        end
        if (reset_n === 1'b1 && bus.d_ready === 1'b1) begin
            n_cmp++;
            if (d_exp_q.size() == 0) begin
                n_err++;
                $display("FAIL d_ready_unexpected: got d_ready=1 expected 0 (no data access pending)");
            end else begin
                d_exp_v = d_exp_q.pop_front();
                if (bus.d_rdata !== d_exp_v) begin
                    n_err++;
                    $display("FAIL sb_d_rdata: got %h expected %h", bus.d_rdata, d_exp_v);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = 16'h0000;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = 16'h0000;
        bus.d_wdata = 16'h0000;
    endtask

    task automatic do_reset();
        next_cycle();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.m_read, bus.m_write, bus.i_ready, bus.d_ready} !== 4'b0000 || dut.state_q !== IDLE) begin
            n_err++;
            $display("FAIL por_ctrl: got rd/wr/irdy/drdy=%b state=%0d expected 0000 state=0",
                     {bus.m_read, bus.m_write, bus.i_ready, bus.d_ready}, dut.state_q);
        end
        n_cmp++;
        if ({bus.m_addr, bus.m_wdata, bus.i_data, bus.d_rdata, conflict_cnt} !== 80'h0) begin
            n_err++;
            $display("FAIL por_data: got addr=%h wdata=%h idata=%h drdata=%h conf=%h expected all 0",
                     bus.m_addr, bus.m_wdata, bus.i_data, bus.d_rdata, conflict_cnt);
        end
        reset_n = 1'b1;
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 16'h0077;
        bus.d_read = 1'b1; bus.d_addr = 16'h0040;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.m_read !== 1'b1 || bus.m_addr !== 16'h0040 || conflict_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL rst_pre: got m_read=%b m_addr=%h conf=%0d expected 1 0040 1",
                     bus.m_read, bus.m_addr, conflict_cnt);
        end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.m_read, bus.m_write, bus.i_ready, bus.d_ready} !== 4'b0000 || dut.state_q !== IDLE) begin
            n_err++;
            $display("FAIL rst_mid_ctrl: got rd/wr/irdy/drdy=%b state=%0d expected 0000 state=0",
                     {bus.m_read, bus.m_write, bus.i_ready, bus.d_ready}, dut.state_q);
        end
        n_cmp++;
        if ({bus.m_addr, bus.i_data, bus.d_rdata, conflict_cnt} !== 64'h0 || dut.d_streak_q !== '0) begin
            n_err++;
            $display("FAIL rst_mid_data: got addr=%h idata=%h drdata=%h conf=%h streak=%0d expected all 0",
                     bus.m_addr, bus.i_data, bus.d_rdata, conflict_cnt, dut.d_streak_q);
        end
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        i_exp_q.push_back(16'hABCD);
        @(negedge clk);
        n_cmp++;
        if (bus.i_stall !== 1'b1 || bus.m_read !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_c0: got i_stall=%b m_read=%b expected 1 0", bus.i_stall, bus.m_read);
        end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) bus.i_req = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (bus.m_read !== (c <= 2) || bus.i_ready !== (c == 2) || bus.m_write !== 1'b0) begin
                n_err++;
                $display("FAIL fetch_c%0d: got m_read=%b i_ready=%b m_write=%b expected %b %b 0",
                         c, bus.m_read, bus.i_ready, bus.m_write, (c <= 2), (c == 2));
            end
            n_cmp++;
            if ((c <= 2 && bus.m_addr !== 16'h0010) || (c >= 2 && bus.i_data !== 16'hABCD)) begin
                n_err++;
                $display("FAIL fetch_data_c%0d: got m_addr=%h i_data=%h expected 0010 ABCD",
                         c, bus.m_addr, bus.i_data);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic exp_rd;
        do_reset();
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 16'h0080;
        bus.d_read = 1'b1; bus.d_addr = 16'h0040;
        d_exp_q.push_back(rdata_f(16'h0040));
        i_exp_q.push_back(rdata_f(16'h0080));
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 3) bus.d_read = 1'b0;
            if (c == 6) bus.i_req = 1'b0;
            @(negedge clk);
            exp_rd = (c == 1 || c == 2 || c == 4 || c == 5);
            n_cmp++;
            if (bus.m_read !== exp_rd || bus.d_ready !== (c == 2) || bus.i_ready !== (c == 5)) begin
                n_err++;
                $display("FAIL simul_c%0d: got m_read=%b d_ready=%b i_ready=%b expected %b %b %b",
                         c, bus.m_read, bus.d_ready, bus.i_ready, exp_rd, (c == 2), (c == 5));
            end
            if (exp_rd) begin
                n_cmp++;
                if (bus.m_addr !== ((c <= 2) ? 16'h0040 : 16'h0080)) begin
                    n_err++;
                    $display("FAIL simul_addr_c%0d: got %h expected %h",
                             c, bus.m_addr, ((c <= 2) ? 16'h0040 : 16'h0080));
                end
            end
        end
        n_cmp++;
        if (conflict_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL conflict_cnt: got %0d expected 2", conflict_cnt);
        end
    endtask

    task automatic test_starvation();
        logic [15:0] exp_addr;
        do_reset();
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 16'h0100;
        bus.d_read = 1'b1; bus.d_addr = 16'h0200;
        for (int g = 0; g < 3; g++) d_exp_q.push_back(rdata_f(16'h0200));
        i_exp_q.push_back(rdata_f(16'h0100));
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            if (c == 12) begin
                bus.i_req = 1'b0;
                bus.d_read = 1'b0;
            end
            @(negedge clk);
            if (c % 3 == 1) begin
                exp_addr = (c == 10) ? 16'h0100 : 16'h0200;
                n_cmp++;
                if (bus.m_read !== 1'b1 || bus.m_addr !== exp_addr) begin
                    n_err++;
                    $display("FAIL starve_grant%0d: got m_read=%b m_addr=%h expected 1 %h",
                             c / 3 + 1, bus.m_read, bus.m_addr, exp_addr);
                end
            end
            if (c == 7 || c == 10) begin
                n_cmp++;
                if (dut.d_streak_q !== ((c == 7) ? 2'd3 : 2'd0)) begin
                    n_err++;
                    $display("FAIL d_streak_c%0d: got %0d expected %0d",
                             c, dut.d_streak_q, (c == 7) ? 3 : 0);
                end
            end
        end
        n_cmp++;
        if (bus.m_read !== 1'b0) begin
            n_err++;
            $display("FAIL starve_end: got m_read=%b expected 0", bus.m_read);
        end
    endtask

    task automatic test_store();
        logic exp_wr;
        do_reset();
        next_cycle();
        bus.d_write = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h1234;
        d_exp_q.push_back(rdata_f(16'h0020));
        for (int c = 0; c <= 3; c++) begin
            if (c != 0) next_cycle();
            if (c == 3) bus.d_write = 1'b0;
            @(negedge clk);
            exp_wr = (c == 1 || c == 2);
            n_cmp++;
            if (bus.m_read !== 1'b0 || bus.m_write !== exp_wr || bus.d_ready !== (c == 2)) begin
                n_err++;
                $display("FAIL store_c%0d: got m_read=%b m_write=%b d_ready=%b expected 0 %b %b",
                         c, bus.m_read, bus.m_write, bus.d_ready, exp_wr, (c == 2));
            end
            if (exp_wr) begin
                n_cmp++;
                if (bus.m_addr !== 16'h0020 || bus.m_wdata !== 16'h1234) begin
                    n_err++;
                    $display("FAIL store_bus_c%0d: got m_addr=%h m_wdata=%h expected 0020 1234",
                             c, bus.m_addr, bus.m_wdata);
                end
            end
        end
    endtask

    task automatic test_read_write_both();
        do_reset();
        next_cycle();
        bus.d_read = 1'b1; bus.d_write = 1'b1;
        bus.d_addr = 16'h0030; bus.d_wdata = 16'h5555;
        d_exp_q.push_back(rdata_f(16'h0030));
        next_cycle();
        bus.d_addr = 16'hFFFF; bus.d_wdata = 16'h0000; bus.d_write = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin
            n_err++;
            $display("FAIL rw_both: got m_write=%b m_read=%b expected 1 0", bus.m_write, bus.m_read);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.m_addr !== 16'h0030 || bus.m_wdata !== 16'h5555 || bus.m_write !== 1'b1 || bus.d_ready !== 1'b1) begin
            n_err++;
            $display("FAIL inflight_hold: got addr=%h wdata=%h m_write=%b d_ready=%b expected 0030 5555 1 1",
                     bus.m_addr, bus.m_wdata, bus.m_write, bus.d_ready);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_store_reset();
        do_reset();
        next_cycle();
        bus.d_write = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h1234;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.m_write !== 1'b1) begin
            n_err++;
            $display("FAIL sr_pre: got m_write=%b expected 1", bus.m_write);
        end
        #1 reset_n = 1'b0;
        bus.d_write = 1'b0;
        #1;
        n_cmp++;
        if (bus.m_write !== 1'b0 || bus.d_ready !== 1'b0 || bus.m_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL sr_abort: got m_write=%b d_ready=%b m_addr=%h expected 0 0 0000",
                     bus.m_write, bus.d_ready, bus.m_addr);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.d_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sr_no_ready: got d_ready=%b expected 0", bus.d_ready);
        end
        reset_n = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 16'h0066;
        i_exp_q.push_back(rdata_f(16'h0066));
        next_cycle();
        n_cmp++;
        if (bus.m_read !== 1'b1 || bus.m_addr !== 16'h0066 || bus.m_write !== 1'b0) begin
            n_err++;
            $display("FAIL sr_first_grant: got m_read=%b m_addr=%h m_write=%b expected 1 0066 0",
                     bus.m_read, bus.m_addr, bus.m_write);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.i_ready !== 1'b1) begin
            n_err++;
            $display("FAIL sr_fetch_ready: got i_ready=%b expected 1", bus.i_ready);
        end
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_read_write_both();
        test_store_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d fetch / %0d data outstanding expected 0 / 0",
                     i_exp_q.size(), d_exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
